pic_wdt_prescaler: RTL and testbench
====================================

Name: pic_wdt_prescaler

Overview:
Watchdog timer and shared 8-bit prescaler for the PIC16C57 core. The block consumes the core's sleep, clear_WDT, clear_prescaler and OPTION_out. It produces WDT_timeout back to the core, plus the TMR0 increment strobe that replaces the core's internal TMR0 clocking. It sits directly beside the core at the top level. The prescaler is assigned to either TMR0 or the WDT by OPTION_out PSA, as on the silicon.

Parameters:
WDT_PERIOD, 1024, clk cycles per WDT base tick (unprescaled nominal period); 2 ≤ WDT_PERIOD ≤ 2^CNT_W
CNT_W, 10, width of the WDT base counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
sleep  in  1  core in SLEEP
clear_WDT  in  1  CLRWDT/SLEEP executed, 1-cycle pulse
clear_prescaler  in  1  write to TMR0 / OPTION, 1-cycle pulse
OPTION_out  in  6  [5]=T0CS, [4]=T0SE, [3]=PSA, [2:0]=PS
T0CKI  in  1  asynchronous external TMR0 clock pin
WDT_timeout  out  1  1-cycle timeout pulse
tmr0_inc  out  1  1-cycle TMR0 increment strobe
wake  out  1  1-cycle pulse: timeout occurred while sleep=1
prescaler_out  out  8  current prescaler value, for debug/verification

Behaviour:
- Reset (rst=1 at edge): wdt_cnt=0, psc=0, sync flops=0, psa_q=OPTION_out[3]. WDT_timeout=0, tmr0_inc=0, wake=0, prescaler_out=0.
- WDT base counter:
  - wdt_cnt counts 0..WDT_PERIOD-1 every cycle, sleeping or not, then wraps to 0.
  - wdt_tick is combinational: (wdt_cnt==WDT_PERIOD-1).
- T0CKI path:
  - 2-flop synchronizer, then a third flop for edge detect.
  - ext_evt = rising edge if T0SE=0, falling edge if T0SE=1.
  - Pin-to-event latency is 3 clk.
- TMR0 source event:
  - src_evt = ext_evt if T0CS=1.
  - Otherwise src_evt = ~sleep, i.e. the internal clock counts every cycle and stops in SLEEP.
- PSA=0 (prescaler on TMR0):
  - psc increments on src_evt.
  - Registered tmr0_inc=1 when src_evt and (psc & M)==M, where M=(2<<PS)-1, giving ratio 1:2^(PS+1).
  - WDT_timeout fires on wdt_tick directly.
- PSA=1 (prescaler on WDT):
  - tmr0_inc=src_evt, registered.
  - psc increments on wdt_tick.
  - Timeout when wdt_tick and (psc & N)==N, where N=(1<<PS)-1, giving ratio 1:2^PS; PS=0 means every tick.
- Outputs are registered: 1-cycle latency from the qualifying condition.
- On timeout:
  - wdt_cnt←0.
  - psc←0 if PSA=1.
  - wake=1 in the same cycle as WDT_timeout if sleep=1.
- psc is 8 bits and wraps 255→0 silently.
- clear_WDT: wdt_cnt←0; also psc←0 if PSA=1. It suppresses any timeout in that cycle (clear wins).
- clear_prescaler: psc←0 and suppresses tmr0_inc in that cycle. clear_prescaler and clear_WDT together clear both counters.
- PSA change (psa_q≠OPTION_out[3]):
  - psc←0 and psa_q updated.
  - No tmr0_inc or prescaled timeout that cycle.
- rst has priority over everything; a mid-count rst discards partial counts.

Optional Feature:
Macro WDTE_FUSE_EN.
- Defined: adds input port wdte (1 bit, the configuration fuse). While wdte=0, wdt_cnt is held at 0 and WDT_timeout/wake stay 0. Prescaler/TMR0 behaviour is unchanged; with PSA=1 the prescaler stays frozen.
- Not defined: no port; the WDT is always enabled.

Test Plan:
- WDT_PERIOD=8, PSA=0, no clears → WDT_timeout pulses at cycles 8, 16, 24 after reset release, each 1 cycle wide.
- WDT_PERIOD=8, PSA=1, PS=2 → timeout every 32 cycles. clear_WDT at cycle 30 → next timeout at cycle 62, prescaler_out=0 after the clear.
- PSA=0, T0CS=0, PS=0 → tmr0_inc every 2nd cycle. sleep=1 → tmr0_inc stops; WDT_timeout during sleep gives wake=1 the same cycle.
- T0CS=1, T0SE=1, PSA=1, T0CKI toggled every 5 cycles → tmr0_inc once per falling edge, 3 cycles after the pin edge.
- clear_WDT asserted exactly on the terminal cycle → no WDT_timeout; wdt_cnt restarts from 0.
- PSA toggled 0→1 with psc=0x35 → prescaler_out=0 next cycle, no spurious pulses. rst pulsed mid-count → all outputs 0 and counters restart.

Source files
------------

// File: rtl/pic_wdt_prescaler.sv
// Watchdog timer and shared 8-bit prescaler for the PIC16C57 core. The PSA bit assigns the prescaler to TMR0 or the WDT.
// Optional build macro WDTE_FUSE_EN adds the wdte fuse input, which gates the WDT.
module pic_wdt_prescaler #(
    parameter int WDT_PERIOD = 1024,
    parameter int CNT_W      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sleep,
    input  logic       clear_WDT,
    input  logic       clear_prescaler,
    input  logic [5:0] OPTION_out,
    input  logic       T0CKI,
`ifdef WDTE_FUSE_EN
    input  logic       wdte,
`endif
    output logic       WDT_timeout,
    output logic       tmr0_inc,
    output logic       wake,
    output logic [7:0] prescaler_out
);

    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_PERIOD - 1);

    logic [CNT_W-1:0] wdt_cnt;
    logic [7:0]       psc;
    logic             t0_s1;
    logic             t0_s2;
    logic             t0_s3;
    logic             psa_q;

    logic       t0cs;
    logic       t0se;
    logic       psa;
    logic [2:0] ps;
    logic       wdt_en;
    logic       wdt_tick;
    logic       ext_evt;
    logic       src_evt;
    logic       psa_chg;
    logic [7:0] m_mask;
    logic [7:0] n_mask;
    logic       inc_cond;
    logic       to_cond;
    logic       psc_clr;
    logic       psc_adv;

    assign t0cs = OPTION_out[5];
    assign t0se = OPTION_out[4];
    assign psa  = OPTION_out[3];
    assign ps   = OPTION_out[2:0];

`ifdef WDTE_FUSE_EN
    assign wdt_en = wdte;
`else
    assign wdt_en = 1'b1;
`endif

    always_comb begin
        wdt_tick = wdt_en && (wdt_cnt == WDT_LAST);
        ext_evt  = t0se ? (~t0_s2 & t0_s3) : (t0_s2 & ~t0_s3);
        src_evt  = t0cs ? ext_evt : ~sleep;
        psa_chg  = (psa_q != psa);
        // 8-bit arithmetic: for PS=7 the shift overflows to 0 and the mask becomes 0xFF
        m_mask   = (8'd2 << ps) - 8'd1;
        n_mask   = (8'd1 << ps) - 8'd1;

        inc_cond = src_evt && !clear_prescaler && !psa_chg
                   && (psa_q || ((psc & m_mask) == m_mask));
        to_cond  = wdt_tick && !clear_WDT
                   && (!psa_q || (!psa_chg && ((psc & n_mask) == n_mask)));

        psc_clr  = clear_prescaler || psa_chg
                   || (psa_q && wdt_en && (clear_WDT || to_cond));
        psc_adv  = psa_q ? wdt_tick : src_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt     <= '0;
            psc         <= 8'd0;
            t0_s1       <= 1'b0;
            t0_s2       <= 1'b0;
            t0_s3       <= 1'b0;
            psa_q       <= OPTION_out[3];
            WDT_timeout <= 1'b0;
            tmr0_inc    <= 1'b0;
            wake        <= 1'b0;
        end else begin
            t0_s1       <= T0CKI;
            t0_s2       <= t0_s1;
            t0_s3       <= t0_s2;
            psa_q       <= psa;
            WDT_timeout <= to_cond;
            tmr0_inc    <= inc_cond;
            wake        <= to_cond && sleep;

            // the terminal tick always restarts the base count, whether or not it times out
            if (!wdt_en || clear_WDT || wdt_tick)
                wdt_cnt <= '0;
            else
                wdt_cnt <= wdt_cnt + CNT_W'(1);

            if (psc_clr)
                psc <= 8'd0;
            else if (psc_adv)
                psc <= psc + 8'd1;
        end
    end

    assign prescaler_out = psc;

endmodule

// File: tb/tb_pic_wdt_prescaler.sv
// Directed bench for pic_wdt_prescaler with WDT_PERIOD=8: a vector table plus hand sequences for
// prescaled timeout, T0CKI edges, PSA change and mid-count reset.
module tb_pic_wdt_prescaler;

    logic       clk = 1'b0;
    logic       rst;
    logic       sleep;
    logic       clear_WDT;
    logic       clear_prescaler;
    logic [5:0] OPTION_out;
    logic       T0CKI;
    logic       WDT_timeout;
    logic       tmr0_inc;
    logic       wake;
    logic [7:0] prescaler_out;

    int checks   = 0;
    int failures = 0;

    pic_wdt_prescaler #(.WDT_PERIOD(8), .CNT_W(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .sleep           (sleep),
        .clear_WDT       (clear_WDT),
        .clear_prescaler (clear_prescaler),
        .OPTION_out      (OPTION_out),
        .T0CKI           (T0CKI),
`ifdef WDTE_FUSE_EN
        .wdte            (1'b1),
`endif
        .WDT_timeout     (WDT_timeout),
        .tmr0_inc        (tmr0_inc),
        .wake            (wake),
        .prescaler_out   (prescaler_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       slp;
        logic       cwdt;
        logic       cpsc;
        logic       inc;
        logic       to;
        logic       wk;
        logic [7:0] psc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [5:0] opt);
        OPTION_out = opt;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic add_vec(input logic s, input logic cw, input logic cp,
                           input logic i, input logic t, input logic w, input logic [7:0] p);
        vec_t v;
        v.slp = s; v.cwdt = cw; v.cpsc = cp; v.inc = i; v.to = t; v.wk = w; v.psc = p;
        vq.push_back(v);
    endtask

    initial begin
        // sleep, clear_WDT, clear_prescaler | tmr0_inc, WDT_timeout, wake, prescaler_out
        // PSA=0, T0CS=0, PS=0: tmr0_inc every 2nd awake cycle, WDT ticks at cycles 8,16(cleared),24
        add_vec(0,0,0, 0,0,0, 8'd1);
        add_vec(0,0,0, 1,0,0, 8'd2);
        add_vec(0,0,0, 0,0,0, 8'd3);
        add_vec(0,0,0, 1,0,0, 8'd4);
        add_vec(1,0,0, 0,0,0, 8'd4);
        add_vec(1,0,0, 0,0,0, 8'd4);
        add_vec(1,0,0, 0,0,0, 8'd4);
        add_vec(1,0,0, 0,1,1, 8'd4);
        add_vec(0,0,0, 0,0,0, 8'd5);
        add_vec(0,0,0, 1,0,0, 8'd6);
        add_vec(0,0,0, 0,0,0, 8'd7);
        add_vec(0,0,1, 0,0,0, 8'd0);
        add_vec(0,0,0, 0,0,0, 8'd1);
        add_vec(0,0,0, 1,0,0, 8'd2);
        add_vec(0,0,0, 0,0,0, 8'd3);
        add_vec(0,1,0, 1,0,0, 8'd4);
        add_vec(0,0,0, 0,0,0, 8'd5);
        add_vec(0,0,0, 1,0,0, 8'd6);
        add_vec(0,0,0, 0,0,0, 8'd7);
        add_vec(0,0,0, 1,0,0, 8'd8);
        add_vec(0,0,0, 0,0,0, 8'd9);
        add_vec(0,0,0, 1,0,0, 8'd10);
        add_vec(0,0,0, 0,0,0, 8'd11);
        add_vec(0,0,0, 1,1,0, 8'd12);

        rst = 1'b1; sleep = 1'b0; clear_WDT = 1'b0; clear_prescaler = 1'b0;
        T0CKI = 1'b0; OPTION_out = 6'b100000;
        #1;

        // Reset state, then unprescaled WDT with no TMR0 source events
        do_reset(6'b100000);
        chk("rst_timeout", 0, {7'd0, WDT_timeout}, 8'd0);
        chk("rst_inc", 0, {7'd0, tmr0_inc}, 8'd0);
        chk("rst_wake", 0, {7'd0, wake}, 8'd0);
        chk("rst_psc", 0, prescaler_out, 8'd0);
        for (int n = 1; n <= 24; n++) begin
            step();
            chk("wdt_plain", n, {7'd0, WDT_timeout}, {7'd0, (n % 8) == 0});
            chk("wdt_plain_inc", n, {7'd0, tmr0_inc}, 8'd0);
        end

        // Vector table
        do_reset(6'b000000);
        for (int k = 0; k < vq.size(); k++) begin
            sleep = vq[k].slp;
            clear_WDT = vq[k].cwdt;
            clear_prescaler = vq[k].cpsc;
            step();
            chk("vec_inc", k + 1, {7'd0, tmr0_inc}, {7'd0, vq[k].inc});
            chk("vec_timeout", k + 1, {7'd0, WDT_timeout}, {7'd0, vq[k].to});
            chk("vec_wake", k + 1, {7'd0, wake}, {7'd0, vq[k].wk});
            chk("vec_psc", k + 1, prescaler_out, vq[k].psc);
        end
        sleep = 1'b0; clear_WDT = 1'b0; clear_prescaler = 1'b0;

        // PSA=1, PS=2: timeout every 4th tick; clear_WDT at cycle 30 pushes it to 62
        do_reset(6'b101010);
        for (int n = 1; n <= 62; n++) begin
            clear_WDT = (n == 30);
            step();
            chk("psa1_timeout", n, {7'd0, WDT_timeout}, {7'd0, n == 62});
            if (n == 24) chk("psa1_psc_before_clr", n, prescaler_out, 8'd3);
            if (n == 30) chk("psa1_psc_after_clr", n, prescaler_out, 8'd0);
            if (n == 62) chk("psa1_psc_after_to", n, prescaler_out, 8'd0);
        end
        clear_WDT = 1'b0;

        // External clock, falling edge, PSA=1: tmr0_inc 3 cycles after each falling pin edge
        T0CKI = 1'b1;
        do_reset(6'b111000);
        for (int n = 1; n <= 40; n++) begin
            step();
            chk("t0cki_inc", n, {7'd0, tmr0_inc},
                {7'd0, (n == 8) || (n == 18) || (n == 28) || (n == 38)});
            if ((n % 5) == 0) T0CKI = ~T0CKI;
        end
        T0CKI = 1'b0;

        // PSA 0->1 with prescaler at 0x35: cleared next cycle, no pulse in the switching cycle
        do_reset(6'b000111);
        for (int n = 1; n <= 53; n++) begin
            step();
            if (tmr0_inc !== 1'b0) chk("psa_sw_pre_inc", n, {7'd0, tmr0_inc}, 8'd0);
        end
        chk("psa_sw_psc_pre", 53, prescaler_out, 8'h35);
        OPTION_out = 6'b001111;
        step();
        chk("psa_sw_psc", 54, prescaler_out, 8'd0);
        chk("psa_sw_inc", 54, {7'd0, tmr0_inc}, 8'd0);
        chk("psa_sw_timeout", 54, {7'd0, WDT_timeout}, 8'd0);
        step();
        chk("psa_sw_psc_hold", 55, prescaler_out, 8'd0);
        chk("psa_sw_inc_after", 55, {7'd0, tmr0_inc}, 8'd1);
        for (int n = 56; n <= 60; n++) step();
        chk("psa_sw_psc_tick", 60, prescaler_out, 8'd1);

        // Mid-count reset discards partial counts
        do_reset(6'b100000);
        chk("midrst_psc", 0, prescaler_out, 8'd0);
        chk("midrst_inc", 0, {7'd0, tmr0_inc}, 8'd0);
        chk("midrst_timeout", 0, {7'd0, WDT_timeout}, 8'd0);
        chk("midrst_wake", 0, {7'd0, wake}, 8'd0);
        for (int n = 1; n <= 8; n++) begin
            step();
            chk("midrst_restart", n, {7'd0, WDT_timeout}, {7'd0, n == 8});
        end

        // Both clears together on the terminal cycle with PSA=1
        do_reset(6'b101010);
        for (int n = 1; n <= 16; n++) begin
            clear_WDT = (n == 16);
            clear_prescaler = (n == 16);
            step();
        end
        chk("both_clr_timeout", 16, {7'd0, WDT_timeout}, 8'd0);
        chk("both_clr_psc", 16, prescaler_out, 8'd0);
        clear_WDT = 1'b0; clear_prescaler = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
